sseg_scan_driver: RTL

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_scan_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - multiplexed 8-digit seven-segment scan driver
//
// Drives one digit of an 8-digit common-anode display at a time. Each digit
// is shown for DIV clock cycles. The displayed data comes from a snapshot
// that is captured only on a load strobe.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   load       - one-cycle strobe that captures hex/dp_in/en_in/lzb
//   hex        - eight 4-bit digits, digit k = hex[4k+3:4k]
//   dp_in      - per-digit decimal point enables (1 = lit)
//   en_in      - per-digit enables (0 = blank)
//   lzb        - leading-zero blanking enable
//   an         - active-low anode selects, an[k] drives digit k
//   sseg       - active-low segments {g,f,e,d,c,b,a}
//   dp         - active-low decimal point
//   frame_tick - one-cycle pulse when digit 0 of a new scan is presented
module sseg_scan_driver #(
  parameter int DIV = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] hex,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        lzb,
  output logic [7:0]  an,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic        frame_tick
);

  // A one-bit prescaler is kept even for DIV=1. It then simply stays at 0.
  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_hex_snap;
  logic [7:0]    r_dp_snap;
  logic [7:0]    r_en_snap;
  logic          r_lzb_snap;
  logic          r_wrap;

  logic          w_adv;
  logic [3:0]    w_digit;
  logic          w_lz_blank;
  logic          w_blank;
  logic [6:0]    w_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_adv = (r_presc == LAST);

  always_comb begin
    w_digit    = r_hex_snap[{r_idx, 2'b00} +: 4];
    // The digit is a leading zero when it and every digit above it are zero.
    // Digit 0 is exempt, so a zero value still shows a single 0.
    w_lz_blank = r_lzb_snap && (r_idx != 3'd0) &&
                 ((r_hex_snap >> {r_idx, 2'b00}) == 32'd0);
    w_blank    = !r_en_snap[r_idx] || w_lz_blank;
    w_seg      = seg_decode(w_digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc    <= '0;
      r_idx      <= 3'd0;
      r_hex_snap <= 32'd0;
      r_dp_snap  <= 8'd0;
      r_en_snap  <= 8'h00;
      r_lzb_snap <= 1'b0;
      r_wrap     <= 1'b0;
      an         <= 8'hFF;
      sseg       <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (w_adv) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (load) begin
        r_hex_snap <= hex;
        r_dp_snap  <= dp_in;
        r_en_snap  <= en_in;
        r_lzb_snap <= lzb;
      end

      // r_wrap marks the first cycle of idx==0 after a 7->0 wrap. It is
      // delayed one more cycle so that it lines up with the registered digit 0.
      r_wrap     <= w_adv && (r_idx == 3'd7);
      frame_tick <= r_wrap;

      if (w_blank) begin
        an   <= 8'hFF;
        sseg <= 7'h7F;
        dp   <= 1'b1;
      end else begin
        an   <= ~(8'd1 << r_idx);
        sseg <= w_seg;
        dp   <= ~r_dp_snap[r_idx];
      end
    end
  end

endmodule
